// File: rtl/fp_result_fifo_if.sv
// Bus bundle between the multiplier wrapper, the result FIFO and its consumer.
// The FIFO takes the slave modport; whoever drives inputs and consumes results takes master.
interface fp_result_fifo_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_class;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             nan_seen;
    logic [15:0]      result_cnt;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_class, out_valid, count, nan_seen, result_cnt
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_class, out_valid, count, nan_seen, result_cnt
    );
endinterface

// File: rtl/fp_result_fifo.sv
// Show-ahead FIFO for single-precision products: stores each value with its IEEE-754 class,
// and keeps a sticky NaN flag plus a wrapping count of accepted results.
module fp_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    fp_result_fifo_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_mem  [DEPTH];
    logic [2:0]       class_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q;
    logic             nan_q;
    logic [15:0]      rc_q;
    logic             rdy, push, pop;
    logic [2:0]       in_class;

    function automatic logic [2:0] classify(input logic [WIDTH-1:0] d);
        logic [7:0]  e;
        logic [22:0] m;
        e = d[30:23];
        m = d[22:0];
        if (e == 8'h00)      classify = (m == '0) ? 3'd0 : 3'd1;
        else if (e == 8'hFF) classify = (m == '0) ? 3'd3 : 3'd4;
        else                 classify = 3'd2;
    endfunction

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        case (state)
            INIT: state_nxt = RUN;
            RUN: begin
                state_nxt = RUN;
                rdy       = (count_q != FULL);
            end
            default: state_nxt = INIT;
        endcase
    end

    // Pop is gated on out_valid, so a pop never happens on an empty FIFO.
    assign push     = bus.in_valid && rdy;
    assign pop      = (count_q != '0) && bus.out_ready;
    assign in_class = classify(bus.in_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            nan_q   <= 1'b0;
            rc_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i]  <= '0;
                class_mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (push) begin
                data_mem[wr_ptr]  <= bus.in_data;
                class_mem[wr_ptr] <= in_class;
                wr_ptr            <= wr_ptr + 1'b1;
                rc_q              <= rc_q + 16'd1;
                if (in_class == 3'd4) nan_q <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.in_ready   = rdy;
    assign bus.out_valid  = (count_q != '0);
    assign bus.out_data   = data_mem[rd_ptr];
    assign bus.out_class  = class_mem[rd_ptr];
    assign bus.count      = count_q;
    assign bus.nan_seen   = nan_q;
    assign bus.result_cnt = rc_q;
endmodule

// File: tb/tb_fp_result_fifo.sv
// Directed bench for fp_result_fifo with a scoreboard of expected value/class pairs.
module tb_fp_result_fifo;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cls;
    } entry_t;

    entry_t      sb[$];
    logic [15:0] m_rc;
    logic        m_nan;
    logic [15:0] rc_base;

    fp_result_fifo_if #(.DEPTH(4), .WIDTH(32)) bus ();
    fp_result_fifo #(.DEPTH(4), .WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_class(input logic [31:0] d);
        if (d[30:23] == 8'd255) return (d[22:0] != 23'd0) ? 3'd4 : 3'd3;
        if (d[30:23] == 8'd0)   return (d[22:0] != 23'd0) ? 3'd1 : 3'd0;
        return 3'd2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are stable at the falling edge, so handshakes that will complete at the
    // next rising edge are scored there; then advance to just past that edge.
    task automatic cyc();
        entry_t e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            m_rc  = '0;
            m_nan = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_on_empty_model", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", bus.out_data, e.data);
                    chk("sb_class", {29'd0, bus.out_class}, {29'd0, e.cls});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.data = bus.in_data;
                e.cls  = exp_class(bus.in_data);
                sb.push_back(e);
                m_rc = m_rc + 16'd1;
                if (e.cls == 3'd4) m_nan = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] vals4 [4];
        logic [31:0] fill4 [4];
        vals4 = '{32'h8000_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000};
        fill4 = '{32'h3F80_0000, 32'hC000_0000, 32'h4120_0000, 32'h0040_0000};

        rst = 1'b1;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        m_rc = '0;
        m_nan = 1'b0;
        cyc();
        cyc();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_class", {29'd0, bus.out_class}, 32'd0);
        chk("rst_count", {29'd0, bus.count}, 32'd0);
        chk("rst_nan", {31'd0, bus.nan_seen}, 32'd0);
        chk("rst_rc", {16'd0, bus.result_cnt}, 32'd0);

        rst = 1'b0;
        #1;
        chk("init_in_ready", {31'd0, bus.in_ready}, 32'd0);
        cyc();
        chk("run_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // single push, show-ahead latency
        bus.out_ready = 1'b1;
        push_one(32'h40C0_0000);
        chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_out_data", bus.out_data, 32'h40C0_0000);
        chk("t1_out_class", {29'd0, bus.out_class}, 32'd2);
        chk("t1_rc", {16'd0, bus.result_cnt}, 32'd1);
        chk("t1_count", {29'd0, bus.count}, 32'd1);
        cyc();
        chk("t1_count_after_pop", {29'd0, bus.count}, 32'd0);
        chk("t1_empty", {31'd0, bus.out_valid}, 32'd0);

        // class coverage: -0, subnormal, inf, NaN
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(vals4[i]);
        chk("t2_nan", {31'd0, bus.nan_seen}, 32'd1);
        chk("t2_count", {29'd0, bus.count}, 32'd4);
        chk("t2_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t2_head_class", {29'd0, bus.out_class}, 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("t2_drained", {29'd0, bus.count}, 32'd0);

        // full: fifth value held off until a slot frees
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(fill4[i]);
        bus.in_data  = 32'h4049_0FDB;
        bus.in_valid = 1'b1;
        cyc();
        chk("t3_count_full", {29'd0, bus.count}, 32'd4);
        chk("t3_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
        chk("t3_rc", {16'd0, bus.result_cnt}, {16'd0, m_rc});
        chk("t3_head_stable", bus.out_data, fill4[0]);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("t3_in_ready_freed", {31'd0, bus.in_ready}, 32'd1);
        chk("t3_count_3", {29'd0, bus.count}, 32'd3);
        cyc();
        bus.in_valid = 1'b0;
        chk("t3_count_refill", {29'd0, bus.count}, 32'd4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("t3_drained", {29'd0, bus.count}, 32'd0);

        // streaming with pointer wrap
        rc_base = bus.result_cnt;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 32'h3F80_0000 + 32'(i) * 32'h0080_0000;
            cyc();
            chk("t4_count_le1", {31'd0, (bus.count <= 3'd1)}, 32'd1);
        end
        bus.in_valid = 1'b0;
        cyc();
        chk("t4_rc", {16'd0, bus.result_cnt}, {16'd0, rc_base + 16'd10});
        chk("t4_empty", {29'd0, bus.count}, 32'd0);

        // reset mid-operation
        bus.out_ready = 1'b0;
        push_one(32'h4000_0000);
        push_one(32'hFFC0_0001);
        push_one(32'h0000_0000);
        chk("t5_count3", {29'd0, bus.count}, 32'd3);
        chk("t5_nan_set", {31'd0, bus.nan_seen}, 32'd1);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("t5_count", {29'd0, bus.count}, 32'd0);
        chk("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t5_nan", {31'd0, bus.nan_seen}, 32'd0);
        chk("t5_rc", {16'd0, bus.result_cnt}, 32'd0);
        chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("t5_init_ready", {31'd0, bus.in_ready}, 32'd0);
        cyc();
        chk("t5_run_ready", {31'd0, bus.in_ready}, 32'd1);

        // result counter wrap after 65536 accepted results
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            bus.in_data = $urandom;
            cyc();
        end
        bus.in_valid = 1'b0;
        cyc();
        chk("t6_rc_wrap", {16'd0, bus.result_cnt}, 32'd0);
        chk("t6_rc_model", {16'd0, bus.result_cnt}, {16'd0, m_rc});
        chk("t6_nan_model", {31'd0, bus.nan_seen}, {31'd0, m_nan});
        chk("t6_empty", {29'd0, bus.count}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_result_fifo.md
# fp_result_fifo

Downstream stage for the FPmul test wrapper: accepts single-precision products over a valid/ready handshake, classifies each one (zero/subnormal/normal/inf/NaN), and buffers value and class in a small show-ahead FIFO for the checker/scoreboard. It also keeps a sticky NaN flag and a running count of accepted results. Its input side connects directly to the multiplier wrapper's output interface (data, valid, ready).

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- WIDTH, 32, data width; IEEE-754 single precision, fixed at 32
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  WIDTH  result from multiplier wrapper
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept this cycle
- out_data  out  WIDTH  head-of-FIFO result
- out_class  out  3  head class: 0 zero, 1 subnormal, 2 normal, 3 infinity, 4 NaN
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head this cycle
- count  out  $clog2(DEPTH+1)  occupied entries
- nan_seen  out  1  sticky: a NaN has been accepted since reset
- result_cnt  out  16  accepted results, wraps modulo 2^16

## Operation
- Control FSM states:
  - INIT: entered on rst; in_ready=0; next cycle → RUN.
  - RUN: normal push/pop; stays in RUN until rst.
- Push: in_valid && in_ready. Stores in_data and its class at wr_ptr; wr_ptr+1 mod DEPTH; result_cnt+1.
- Pop: out_valid && out_ready. rd_ptr+1 mod DEPTH.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- in_ready = (state==RUN) && (count < DEPTH). Combinational from registered state.
- out_valid = (count != 0). out_data/out_class read the rd_ptr entry (show-ahead).
- Classification, exp=in_data[30:23], man=in_data[22:0]:
  - exp==0, man==0 → 0 (covers −0)
  - exp==0, man!=0 → 1
  - exp==255, man==0 → 3
  - exp==255, man!=0 → 4
  - otherwise → 2
- Sign is ignored for class.
- nan_seen sets on a push with class 4. Cleared only by rst.
- Full (count==DEPTH): in_ready=0; a pop frees one slot, seen next cycle. No same-cycle bypass on full.
- Empty (count==0): pop impossible. out_data holds the last stored entry and is don't-care for the checker.
- Simultaneous push and pop at 0<count<DEPTH: both happen, count unchanged.
- Pointers wrap from DEPTH−1 to 0. result_cnt wraps from 0xFFFF to 0.
- rst mid-operation: buffered entries discarded, pointers zeroed, no output handshake completes that cycle.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_class=0, count=0, nan_seen=0, result_cnt=0, state=INIT.
- First cycle after rst deassert: state=INIT, in_ready=0. Following cycle: in_ready=1.
- Latency: push at edge N → out_valid=1 with that data after edge N; consumer can pop at edge N+1.
- Throughput: one push and one pop per cycle when neither full nor empty.
- Handshake: in_data/in_valid sampled only when in_ready=1. out_data/out_class/out_valid stay stable while out_valid && !out_ready.
- count, nan_seen, result_cnt update at the same edge as the triggering handshake.

## Test plan
- Reset then single push 0x40C00000 (6.0), out_ready=1 → next cycle out_valid=1, out_data=0x40C00000, out_class=2; result_cnt=1; count back to 0 after pop.
- Push 0x80000000, 0x00000001, 0x7F800000, 0x7FC00000 with out_ready=0 → out_class sequence on pops 0,1,3,4; nan_seen=1 after the 4th push; count=4; in_ready=0.
- Fill 4 entries, then a 5th in_valid with out_ready=0 → not accepted, count=4, result_cnt=4. Assert out_ready one cycle → in_ready=1 next cycle; the 5th value is accepted and emerges after the first four, in order.
- Streaming 10 values with in_valid=out_ready=1 for consecutive cycles → count stays ≤1, output order equals input order, pointers wrap correctly, result_cnt=10.
- rst asserted with count=3, nan_seen=1 → next cycle count=0, out_valid=0, nan_seen=0, result_cnt=0, in_ready=0; in_ready=1 two cycles after deassert.
- Preload result_cnt path with 65536 pushes → result_cnt wraps to 0.
